// File: rtl/assert_ctl_sched.sv
// Round-robin scheduler that serialises assertion on/off/kill commands onto a per-scope enable register
// and gates, counts and flags scope failures. Failure counters are built only with ASSERT_CTL_SCHED_CNT_EN.
module assert_ctl_sched #(
  parameter int NREQ   = 4,
  parameter int NSCOPE = 8,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [NSCOPE*NREQ-1:0]  req_mask,
  output logic [NREQ-1:0]         cmd_done,
  input  logic [NSCOPE-1:0]       fail_in,
  output logic [NSCOPE-1:0]       scope_en,
  output logic                    fail_any,
  output logic [NSCOPE*CNT_W-1:0] fail_cnt
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    OP_ON   = 2'b00,
    OP_OFF  = 2'b01,
    OP_KILL = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_cand [NREQ];
  logic              w_grant_vld;
  logic [PTR_W-1:0]  w_grant_id;
  logic              w_xfer;
  logic [1:0]        w_sel_op;
  logic [NSCOPE-1:0] w_sel_mask;

  logic              r_cmd_vld;
  op_e               r_cmd_op;
  logic [NSCOPE-1:0] r_cmd_mask;
  logic [PTR_W-1:0]  r_cmd_id;
  logic              w_apply;

  logic [NSCOPE-1:0] r_scope_en;
  logic [NSCOPE-1:0] w_scope_en_nxt;
  logic [NSCOPE-1:0] w_fail_en;
  logic              r_fail_any;

  // Handshake: a command transfers when req_valid[i] and req_ready[i] are both high at a rising edge;
  // ready is a combinational one-hot grant, withheld while rst is high.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand[k] = PTR_W'((int'(r_ptr) + k) % NREQ);
      if (!w_grant_vld && req_valid[w_cand[k]]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_cand[k];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    w_xfer    = w_grant_vld & ~rst;
    if (w_xfer) req_ready[w_grant_id] = 1'b1;
  end

  always_comb begin
    w_sel_op   = '0;
    w_sel_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_id == PTR_W'(i)) begin
        w_sel_op   = req_op[2*i +: 2];
        w_sel_mask = req_mask[NSCOPE*i +: NSCOPE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_cmd_vld <= 1'b0;
    end else begin
      r_cmd_vld <= w_xfer;
      if (w_xfer) begin
        r_cmd_op   <= op_e'(w_sel_op);
        r_cmd_mask <= w_sel_mask;
        r_cmd_id   <= w_grant_id;
        r_ptr      <= PTR_W'((int'(w_grant_id) + 1) % NREQ);
      end
    end
  end

  // A command still in cmd_q when reset is applied is dropped silently.
  assign w_apply = r_cmd_vld & ~rst;

  always_comb begin
    cmd_done = '0;
    if (w_apply) cmd_done[r_cmd_id] = 1'b1;
  end

`ifdef ASSERT_CTL_SCHED_CNT_EN
  logic [NSCOPE-1:0] w_kill_mask;
`endif

  always_comb begin
    w_scope_en_nxt = r_scope_en;
`ifdef ASSERT_CTL_SCHED_CNT_EN
    w_kill_mask = '0;
`endif
    if (w_apply) begin
      case (r_cmd_op)
        OP_ON:  w_scope_en_nxt = r_scope_en | r_cmd_mask;
        OP_OFF: w_scope_en_nxt = r_scope_en & ~r_cmd_mask;
        OP_KILL: begin
          w_scope_en_nxt = r_scope_en & ~r_cmd_mask;
`ifdef ASSERT_CTL_SCHED_CNT_EN
          w_kill_mask = r_cmd_mask;
`endif
        end
        default: w_scope_en_nxt = r_scope_en;
      endcase
    end
  end

  // Gating uses the enable as it stood at the start of the cycle, so an OFF still lets this cycle's failure through.
  assign w_fail_en = fail_in & r_scope_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scope_en <= '1;
      r_fail_any <= 1'b0;
    end else begin
      r_scope_en <= w_scope_en_nxt;
      r_fail_any <= |w_fail_en;
    end
  end

  assign scope_en = r_scope_en;
  assign fail_any = r_fail_any;

`ifdef ASSERT_CTL_SCHED_CNT_EN
  logic [CNT_W-1:0] r_cnt [NSCOPE];

  // Kill clear takes priority over a same-cycle increment; counters saturate at all-ones.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSCOPE; s++) begin
      if (rst) begin
        r_cnt[s] <= '0;
      end else if (w_kill_mask[s]) begin
        r_cnt[s] <= '0;
      end else if (w_fail_en[s] && (r_cnt[s] != {CNT_W{1'b1}})) begin
        r_cnt[s] <= r_cnt[s] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    fail_cnt = '0;
    for (int s = 0; s < NSCOPE; s++) fail_cnt[CNT_W*s +: CNT_W] = r_cnt[s];
  end
`else
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_assert_ctl_sched.sv
// Bench for assert_ctl_sched: directed scenarios plus random traffic checked against a queue-based model.
module tb_assert_ctl_sched;
  localparam int NREQ    = 4;
  localparam int NSCOPE  = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ASSERT_CTL_SCHED_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [2*NREQ-1:0]       req_op;
  logic [NSCOPE*NREQ-1:0]  req_mask;
  logic [NREQ-1:0]         cmd_done;
  logic [NSCOPE-1:0]       fail_in;
  logic [NSCOPE-1:0]       scope_en;
  logic                    fail_any;
  logic [NSCOPE*CNT_W-1:0] fail_cnt;

  assert_ctl_sched #(.NREQ(NREQ), .NSCOPE(NSCOPE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_mask(req_mask),
    .cmd_done(cmd_done), .fail_in(fail_in),
    .scope_en(scope_en), .fail_any(fail_any), .fail_cnt(fail_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    int                id;
    logic [1:0]        op;
    logic [NSCOPE-1:0] mask;
  } cmd_t;

  // scoreboard: commands accepted but not yet applied
  cmd_t exp_q[$];
  int   obs_grant[$];

  bit                rq_v    [NREQ];
  logic [1:0]        rq_op   [NREQ];
  logic [NSCOPE-1:0] rq_mask [NREQ];

  int                m_ptr;
  logic [NSCOPE-1:0] m_en;
  int                m_cnt [NSCOPE];
  logic              m_fail_any;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr      = 0;
    m_en       = '1;
    m_fail_any = 1'b0;
    for (int s = 0; s < NSCOPE; s++) m_cnt[s] = 0;
  endtask

  function automatic int winner();
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (rq_v[i]) return i;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]                 = rq_v[i];
      req_op[2*i +: 2]             = rq_op[i];
      req_mask[NSCOPE*i +: NSCOPE] = rq_mask[i];
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [NSCOPE-1:0] mask);
    rq_v[i]    = 1'b1;
    rq_op[i]   = op;
    rq_mask[i] = mask;
  endtask

  task automatic gen_req(input int pct, input bit nop_only);
    int r;
    for (int i = 0; i < NREQ; i++) begin
      if (!rq_v[i] && ($urandom_range(0, 99) < pct)) begin
        r = $urandom_range(0, 9);
        set_req(i, nop_only ? 2'b11 : 2'($urandom_range(0, 3)),
                (r == 0) ? '0 : (r == 1) ? '1 : NSCOPE'($urandom));
      end
    end
  endtask

  // One cycle: check outputs at the falling edge, advance the model, then move past the rising edge.
  task automatic step();
    int                      w;
    logic [NREQ-1:0]         exp_rdy;
    logic [NREQ-1:0]         exp_done;
    logic [NSCOPE*CNT_W-1:0] exp_cnt;
    logic [NSCOPE-1:0]       gate;
    logic [NSCOPE-1:0]       kill;
    cmd_t                    c;
    drive();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_grant.push_back(i);
    w = rst ? -1 : winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    exp_done = '0;
    if (exp_q.size() > 0 && !rst) exp_done[exp_q[0].id] = 1'b1;
    if (!rst) check_eq("req_ready", req_ready, exp_rdy);
    check_eq("cmd_done", cmd_done, exp_done);
    check_eq("scope_en", scope_en, m_en);
    check_eq("fail_any", fail_any, m_fail_any);
    exp_cnt = '0;
    for (int s = 0; s < NSCOPE; s++) if (CNT_ON) exp_cnt[CNT_W*s +: CNT_W] = CNT_W'(m_cnt[s]);
    check_eq("fail_cnt", fail_cnt, exp_cnt);

    if (rst) begin
      model_reset();
    end else begin
      gate = fail_in & m_en;
      kill = '0;
      if (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        case (c.op)
          2'b00: m_en = m_en | c.mask;
          2'b01: m_en = m_en & ~c.mask;
          2'b10: begin m_en = m_en & ~c.mask; kill = c.mask; end
          default: ;
        endcase
      end
      for (int s = 0; s < NSCOPE; s++) begin
        if (kill[s]) m_cnt[s] = 0;
        else if (gate[s] && m_cnt[s] < CNT_MAX) m_cnt[s]++;
      end
      m_fail_any = |gate;
      if (w >= 0) begin
        c.id = w; c.op = rq_op[w]; c.mask = rq_mask[w];
        exp_q.push_back(c);
        m_ptr   = (w + 1) % NREQ;
        rq_v[w] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    fail_in = '0;
    for (int i = 0; i < NREQ; i++) begin rq_v[i] = 1'b0; rq_op[i] = 2'b11; rq_mask[i] = '0; end
    model_reset();
    drive();
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // idle, then a single failure on scope 0
    repeat (2) step();
    fail_in = 8'h01; step();
    fail_in = '0;    step();

    // OFF scope 0 from requester 1, failure now masked, then a repeated OFF
    set_req(1, 2'b01, 8'h01); repeat (3) step();
    fail_in = 8'h01; step();
    fail_in = '0;    step();
    set_req(1, 2'b01, 8'h01); repeat (3) step();

    // all requesters valid with NOP: pointer sits at 2 after the two grants to requester 1
    obs_grant.delete();
    repeat (8) begin gen_req(100, 1'b1); step(); end
    check_eq("rr_count", obs_grant.size(), 8);
    for (int k = 0; k < obs_grant.size() && k < 8; k++) check_eq("rr_order", obs_grant[k], (2 + k) % NREQ);
    repeat (6) step();

    // saturation on scope 2, kill racing a failure, then ON
    fail_in = 8'h04;
    repeat (300) step();
    set_req(0, 2'b10, 8'h04);
    repeat (3) step();
    fail_in = '0;
    set_req(2, 2'b00, 8'h04);
    repeat (3) step();

    // kill on scope 7
    set_req(0, 2'b10, 8'h80); repeat (3) step();
    fail_in = 8'h80; step();
    fail_in = '0;    step();

    // reset while a command sits in the pipeline register
    set_req(3, 2'b01, 8'hF0); step();
    rst = 1'b1; step();
    rst = 1'b0; repeat (2) step();

    // random traffic
    repeat (2000) begin
      gen_req(40, 1'b0);
      fail_in = ($urandom_range(0, 3) == 0) ? NSCOPE'($urandom) : '0;
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end
    rst     = 1'b0;
    fail_in = '0;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
